oled_i2c_sequencer: RTL and testbench



---
 rtl/oled_pkg.sv | 34 +++
 rtl/oled_init_rom.sv | 16 +
 rtl/oled_i2c_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_oled_i2c_sequencer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 I2C bring-up sequencer.
package oled_pkg;

  typedef enum logic [3:0] {
    StPwrWait,
    StAddr,
    StCtrl,
    StData,
    StWaitAddr,
    StWaitCtrl,
    StWaitData,
    StAbort,
    StAbortWait,
    StGap,
    StDone,
    StReady,
    StError
  } state_e;

  localparam logic [6:0] DEV_ADDR_DFLT = 7'h3C;
  localparam logic [7:0] CTRL_CMD      = 8'h00;
  localparam logic [7:0] ABORT_BYTE    = 8'hFF;

  localparam int unsigned INIT_TABLE_LEN = 25;

  // Display off, clocking, mux, offset, start line, charge pump, addressing,
  // remap, COM scan/pins, contrast, precharge, VCOMH, resume, normal, display on.
  localparam logic [7:0] INIT_TABLE [INIT_TABLE_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

endpackage

// File: rtl/oled_init_rom.sv
// Combinational lookup of the SSD1306 init command table.
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [4:0] idx_i,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = 8'h00;
    if (idx_i < 5'(INIT_TABLE_LEN)) begin
      byte_o = INIT_TABLE[idx_i];
    end
  end

endmodule

// File: rtl/oled_i2c_sequencer.sv
// Drives a byte-level I2C master: power-up delay, init table write, then
// single-command runtime writes, with NACK abort/retry and sticky error.
module oled_i2c_sequencer
  import oled_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = DEV_ADDR_DFLT,
  parameter int unsigned PWR_CYCLES = 50000,
  parameter int unsigned RETRY_GAP  = 1000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned INIT_LEN   = 25
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       i2c_valid_o,
  input  logic       i2c_ready_i,
  output logic [7:0] i2c_byte_o,
  output logic       i2c_start_o,
  output logic       i2c_stop_o,
  input  logic       i2c_done_i,
  input  logic       i2c_nack_i,
  input  logic       req_valid_i,
  input  logic [7:0] req_cmd_i,
  output logic       req_ready_o,
  output logic       init_done_o,
  output logic       busy_o,
  output logic       error_o
);

  localparam logic [16:0] PwrLast  = 17'(PWR_CYCLES - 1);
  localparam logic [16:0] GapLast  = 17'(RETRY_GAP - 1);
  localparam logic [2:0]  MaxRetry = 3'(MAX_RETRY);
  localparam logic [4:0]  InitLast = 5'(INIT_LEN - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  retry_q, retry_d;
  logic [16:0] timer_q, timer_d;
  logic        src_init_q, src_init_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        init_done_q, init_done_d;

  logic [7:0] rom_byte;
  logic [7:0] payload;
  logic       last_byte;

  oled_init_rom u_rom (
    .idx_i  (idx_q),
    .byte_o (rom_byte)
  );

  assign payload     = src_init_q ? rom_byte : cmd_q;
  assign last_byte   = src_init_q ? (idx_q == InitLast) : 1'b1;
  assign init_done_o = init_done_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    src_init_d  = src_init_q;
    cmd_d       = cmd_q;
    init_done_d = init_done_q;
    i2c_valid_o = 1'b0;
    i2c_byte_o  = 8'h00;
    i2c_start_o = 1'b0;
    i2c_stop_o  = 1'b0;
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    error_o     = 1'b0;

    unique case (state_q)
      StPwrWait: begin
        if (timer_q == PwrLast) begin
          timer_d    = '0;
          idx_d      = '0;
          src_init_d = 1'b1;
          state_d    = StAddr;
        end else begin
          timer_d = timer_q + 17'd1;
        end
      end
      StAddr: begin
        i2c_valid_o = 1'b1;
        i2c_byte_o  = {DEV_ADDR, 1'b0};
        i2c_start_o = 1'b1;
        if (i2c_ready_i) state_d = StWaitAddr;
      end
      StCtrl: begin
        i2c_valid_o = 1'b1;
        i2c_byte_o  = CTRL_CMD;
        if (i2c_ready_i) state_d = StWaitCtrl;
      end
      StData: begin
        i2c_valid_o = 1'b1;
        i2c_byte_o  = payload;
        i2c_stop_o  = last_byte;
        if (i2c_ready_i) state_d = StWaitData;
      end
      StWaitAddr: begin
        if (i2c_done_i) state_d = i2c_nack_i ? StAbort : StCtrl;
      end
      StWaitCtrl: begin
        if (i2c_done_i) state_d = i2c_nack_i ? StAbort : StData;
      end
      StWaitData: begin
        if (i2c_done_i) begin
          if (i2c_nack_i) begin
            // A NACKed stop byte already closed the frame; no dummy needed.
            if (last_byte) begin
              retry_d = retry_q + 3'd1;
              timer_d = '0;
              state_d = StGap;
            end else begin
              state_d = StAbort;
            end
          end else if (last_byte) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StData;
          end
        end
      end
      StAbort: begin
        i2c_valid_o = 1'b1;
        i2c_byte_o  = ABORT_BYTE;
        i2c_stop_o  = 1'b1;
        if (i2c_ready_i) state_d = StAbortWait;
      end
      StAbortWait: begin
        if (i2c_done_i) begin
          retry_d = retry_q + 3'd1;
          timer_d = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (retry_q > MaxRetry) begin
          state_d = StError;
        end else if (timer_q == GapLast) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = StAddr;
        end else begin
          timer_d = timer_q + 17'd1;
        end
      end
      StDone: begin
        init_done_d = 1'b1;
        retry_d     = '0;
        state_d     = StReady;
      end
      StReady: begin
        busy_o      = 1'b0;
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          cmd_d      = req_cmd_i;
          src_init_d = 1'b0;
          idx_d      = '0;
          state_d    = StAddr;
        end
      end
      StError: begin
        busy_o  = 1'b0;
        error_o = 1'b1;
      end
      default: state_d = StPwrWait;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StPwrWait;
      idx_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      src_init_q  <= 1'b1;
      cmd_q       <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      src_init_q  <= src_init_d;
      cmd_q       <= cmd_d;
      init_done_q <= init_done_d;
    end
  end

endmodule

// File: tb/tb_oled_i2c_sequencer.sv
// Self-checking bench: randomized I2C slave timing and commands against a
// byte-list reference of the expected wire traffic.
module tb_oled_i2c_sequencer;

  localparam int PWR  = 10;
  localparam int GAP  = 4;
  localparam int MAXR = 3;
  localparam int ILEN = 25;
  localparam logic [7:0] ADDR_BYTE = 8'h78;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i2c_valid, i2c_start, i2c_stop;
  logic       i2c_ready = 1'b0, i2c_done = 1'b0, i2c_nack = 1'b0;
  logic [7:0] i2c_byte;
  logic       req_valid = 1'b0;
  logic [7:0] req_cmd = 8'h00;
  logic       req_ready, init_done, busy, error;

  logic [7:0] tbl [ILEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
    8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  int n_cmp = 0;
  int n_err = 0;

  // Wire log and reference, each entry {start, stop, byte}.
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int         gaps_q[$];

  bit pending = 0;
  int delay = 0;
  bit pend_nack = 0;
  int nack_mode = 0;
  bit first_nacked = 0;
  int hold_at = -1;
  int hold_cnt = 0;
  int held_ok = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  bit valid_prev = 0;
  int overlap_err = 0;
  int early_ready = 0;

  always #5 clk = ~clk;

  oled_i2c_sequencer #(
    .DEV_ADDR   (7'h3C),
    .PWR_CYCLES (PWR),
    .RETRY_GAP  (GAP),
    .MAX_RETRY  (MAXR),
    .INIT_LEN   (ILEN)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .i2c_valid_o (i2c_valid),
    .i2c_ready_i (i2c_ready),
    .i2c_byte_o  (i2c_byte),
    .i2c_start_o (i2c_start),
    .i2c_stop_o  (i2c_stop),
    .i2c_done_i  (i2c_done),
    .i2c_nack_i  (i2c_nack),
    .req_valid_i (req_valid),
    .req_cmd_i   (req_cmd),
    .req_ready_o (req_ready),
    .init_done_o (init_done),
    .busy_o      (busy),
    .error_o     (error)
  );

  // Slave model: random ready, random done latency, scripted NACKs.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (!rst_n) begin
        pending    = 0;
        valid_prev = 0;
        i2c_ready  = 1'b0;
        continue;
      end
      if (pending) begin
        if (delay == 0) begin
          i2c_done      = 1'b1;
          i2c_nack      = pend_nack;
          pending       = 0;
          last_done_cyc = cyc;
        end else begin
          delay--;
        end
      end
      if (i2c_valid && !valid_prev) gaps_q.push_back(cyc - last_done_cyc - 1);
      valid_prev = i2c_valid;
      if (i2c_valid && (pending || i2c_done)) overlap_err++;
      if (req_ready && !init_done) early_ready++;
      if (i2c_valid && hold_cnt > 0 && got_q.size() == hold_at) begin
        i2c_ready = 1'b0;
        hold_cnt--;
        if ({i2c_start, i2c_stop, i2c_byte} == {2'b10, ADDR_BYTE}) held_ok++;
      end else begin
        i2c_ready = ($urandom_range(0, 3) != 0);
      end
      if (i2c_valid && i2c_ready) begin
        got_q.push_back({i2c_start, i2c_stop, i2c_byte});
        pending   = 1;
        delay     = $urandom_range(0, 3);
        pend_nack = 0;
        if (i2c_start && i2c_byte == ADDR_BYTE) begin
          if (nack_mode == 2) pend_nack = 1;
          else if (nack_mode == 1 && !first_nacked) begin
            pend_nack    = 1;
            first_nacked = 1;
          end
        end
        if (nack_mode != 0 && i2c_stop && i2c_byte == 8'hFF) pend_nack = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  function automatic void exp_init_frame();
    exp_q.push_back({2'b10, ADDR_BYTE});
    exp_q.push_back({2'b00, 8'h00});
    for (int i = 0; i < ILEN; i++) exp_q.push_back({1'b0, (i == ILEN - 1), tbl[i]});
  endfunction

  function automatic void exp_cmd_frame(input logic [7:0] cmd);
    exp_q.push_back({2'b10, ADDR_BYTE});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b01, cmd});
  endfunction

  function automatic void exp_abort_attempt();
    exp_q.push_back({2'b10, ADDR_BYTE});
    exp_q.push_back({2'b01, 8'hFF});
  endfunction

  function automatic int first_diff();
    int lim;
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return lim;
    return -1;
  endfunction

  function automatic logic [9:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 10'h3FF;
  endfunction

  function automatic logic [9:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 10'h3FF;
  endfunction

  task automatic reset_dut(input int nm, input int h_at, input int h_cnt);
    int n;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_cmd   = 8'h00;
    repeat (3) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    gaps_q.delete();
    nack_mode    = nm;
    first_nacked = 0;
    hold_at      = h_at;
    hold_cnt     = h_cnt;
    held_ok      = 0;
    overlap_err  = 0;
    early_ready  = 0;
    #1 rst_n = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #2;
      n++;
      if (i2c_valid) break;
    end
    n_cmp++;
    if (n != PWR) begin
      n_err++;
      $display("FAIL pwr_delay: first valid after %0d cycles, want %0d", n, PWR);
    end
  endtask

  task automatic wait_settle(input string name);
    int n;
    int early;
    bit ok;
    n = 0;
    early = 0;
    ok = 0;
    while (n < 5000) begin
      @(posedge clk);
      #2;
      n++;
      if (req_ready && got_q.size() < exp_q.size()) early++;
      if (!busy && !pending && got_q.size() >= exp_q.size()) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%0b bytes=%0d want %0d", name, busy, got_q.size(),
               exp_q.size());
    end
    n_cmp++;
    if (early != 0) begin
      n_err++;
      $display("FAIL %s_req_ready: high %0d cycles mid-transaction, want 0", name, early);
    end
  endtask

  task automatic test_reset();
    int d;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({i2c_valid, i2c_byte, i2c_start, i2c_stop, req_ready, init_done, busy, error} !==
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_vals: got %b want %b",
               {i2c_valid, i2c_byte, i2c_start, i2c_stop, req_ready, init_done, busy, error},
               15'b000000000000010);
    end
    reset_dut(0, -1, 0);
    exp_init_frame();
    wait_settle("init");
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL init_seq: entry %0d got %h want %h (count %0d want %0d)", d, got_at(d),
               exp_at(d), got_q.size(), exp_q.size());
    end
    n_cmp++;
    if ({init_done, busy, req_ready, error} !== 4'b1010) begin
      n_err++;
      $display("FAIL init_status: done/busy/rdy/err got %b want 1010",
               {init_done, busy, req_ready, error});
    end
    n_cmp++;
    if (overlap_err != 0) begin
      n_err++;
      $display("FAIL one_outstanding: %0d offers while a byte was pending, want 0", overlap_err);
    end
  endtask

  task automatic test_hold_ready();
    int d;
    reset_dut(0, 0, 5);
    exp_init_frame();
    wait_settle("hold");
    n_cmp++;
    if (held_ok != 5) begin
      n_err++;
      $display("FAIL hold_stable: stable ADDR offer %0d cycles, want 5", held_ok);
    end
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL hold_seq: entry %0d got %h want %h", d, got_at(d), exp_at(d));
    end
  endtask

  task automatic test_nack_retry();
    int d;
    int g;
    reset_dut(1, -1, 0);
    exp_abort_attempt();
    exp_init_frame();
    wait_settle("retry");
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL retry_seq: entry %0d got %h want %h", d, got_at(d), exp_at(d));
    end
    g = (gaps_q.size() > 2) ? gaps_q[2] : -1;
    n_cmp++;
    if (g != GAP) begin
      n_err++;
      $display("FAIL retry_gap: idle cycles before retry %0d, want %0d", g, GAP);
    end
    n_cmp++;
    if ({init_done, busy, error} !== 3'b100) begin
      n_err++;
      $display("FAIL retry_status: done/busy/err got %b want 100", {init_done, busy, error});
    end
  endtask

  task automatic test_nack_all();
    int d;
    int v;
    reset_dut(2, -1, 0);
    for (int i = 0; i < MAXR + 1; i++) exp_abort_attempt();
    wait_settle("give_up");
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL give_up_seq: entry %0d got %h want %h (count %0d want %0d)", d,
               got_at(d), exp_at(d), got_q.size(), exp_q.size());
    end
    n_cmp++;
    if ({error, busy, req_ready, init_done} !== 4'b1000) begin
      n_err++;
      $display("FAIL give_up_status: err/busy/rdy/done got %b want 1000",
               {error, busy, req_ready, init_done});
    end
    v = 0;
    repeat (50) begin
      @(posedge clk);
      #2;
      if (i2c_valid) v++;
    end
    n_cmp++;
    if (v != 0 || !error) begin
      n_err++;
      $display("FAIL error_quiet: valid %0d cycles err=%0b, want 0 and 1", v, error);
    end
  endtask

  task automatic send_req(input logic [7:0] cmd, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    req_valid = 1'b1;
    req_cmd   = cmd;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd   = 8'($urandom);
  endtask

  task automatic test_runtime();
    int d;
    bit ok;
    logic [7:0] cmd;
    reset_dut(0, -1, 0);
    exp_init_frame();
    wait_settle("rt_init");
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      cmd = (k == 0) ? 8'hA7 : 8'($urandom);
      send_req(cmd, ok);
      exp_cmd_frame(cmd);
      n_cmp++;
      if (!ok || {req_ready, busy} !== 2'b01) begin
        n_err++;
        $display("FAIL rt_accept: cmd %h ok=%0b rdy/busy got %b want 01", cmd, ok,
                 {req_ready, busy});
      end
      wait_settle("rt_cmd");
    end
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL rt_seq: entry %0d got %h want %h", d, got_at(d), exp_at(d));
    end
    n_cmp++;
    if ({init_done, busy, req_ready, error} !== 4'b1010) begin
      n_err++;
      $display("FAIL rt_status: done/busy/rdy/err got %b want 1010",
               {init_done, busy, req_ready, error});
    end
  endtask

  task automatic test_req_during_init();
    int d;
    int n;
    logic [7:0] cmd;
    reset_dut(0, -1, 0);
    exp_init_frame();
    cmd = 8'($urandom);
    req_valid = 1'b1;
    req_cmd   = cmd;
    n = 0;
    @(negedge clk);
    #1;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (!req_ready || !init_done || early_ready != 0) begin
      n_err++;
      $display("FAIL early_req: rdy=%0b done=%0b early=%0d, want 1 1 0", req_ready, init_done,
               early_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_cmd_frame(cmd);
    wait_settle("held_req");
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL held_req_seq: entry %0d got %h want %h", d, got_at(d), exp_at(d));
    end
  endtask

  task automatic test_reset_mid();
    int d;
    int n;
    reset_dut(0, 9, 100000);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #2;
      n++;
      if (i2c_valid && got_q.size() == 9) break;
    end
    n_cmp++;
    if ({i2c_valid, i2c_stop, i2c_byte} !== {1'b1, 1'b0, tbl[7]}) begin
      n_err++;
      $display("FAIL mid_offer: valid/stop/byte got %b/%b/%h want 1/0/%h", i2c_valid, i2c_stop,
               i2c_byte, tbl[7]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({i2c_valid, i2c_byte, i2c_start, i2c_stop, req_ready, init_done, busy, error} !==
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset_vals: got %b want %b",
               {i2c_valid, i2c_byte, i2c_start, i2c_stop, req_ready, init_done, busy, error},
               15'b000000000000010);
    end
    hold_cnt = 0;
    reset_dut(0, -1, 0);
    exp_init_frame();
    wait_settle("restart");
    d = first_diff();
    n_cmp++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL restart_seq: entry %0d got %h want %h", d, got_at(d), exp_at(d));
    end
  endtask

  initial begin
    test_reset();
    test_hold_ready();
    test_nack_retry();
    test_nack_all();
    test_runtime();
    test_req_during_init();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
